ex_operand_stage: RTL

ID/EX pipeline register and operand-select stage directly upstream of the ALU. Captures decoded instruction fields from ID, resolves EX/MEM and MEM/WB forwarding, and drives the ALU's `SrcA`, `SrcB` and `Operation`. Also detects load-use hazards and inserts bubbles. Holds on stall and clears on flush.

---
 rtl/ex_operand_stage_if.sv | 74 +++++++
 rtl/ex_operand_stage.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if
// Bundles the ID-side instruction fields, the EX/MEM and MEM/WB forwarding
// sources, and the ALU-facing outputs of the ID/EX operand stage.
//   master : upstream driver (decode + forwarding network); drives id_*,
//            stall/flush and forwarding sources, observes stage outputs.
//   slave  : the operand stage itself.
interface ex_operand_stage_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
);
    // ID stage fields
    logic                     id_valid;
    logic [DATA_WIDTH-1:0]    id_rs1_data;
    logic [DATA_WIDTH-1:0]    id_rs2_data;
    logic [DATA_WIDTH-1:0]    id_imm;
    logic [DATA_WIDTH-1:0]    id_pc;
    logic [REG_ADDR-1:0]      id_rs1;
    logic [REG_ADDR-1:0]      id_rs2;
    logic [REG_ADDR-1:0]      id_rd;
    logic                     id_asel;
    logic                     id_alusrc;
    logic [OPCODE_LENGTH-1:0] id_operation;
    logic                     id_regwrite;
    logic                     id_memread;
    logic                     id_memwrite;

    // pipeline control
    logic                     stall;
    logic                     flush;

    // forwarding sources
    logic                     mem_regwrite;
    logic [REG_ADDR-1:0]      mem_rd;
    logic [DATA_WIDTH-1:0]    mem_result;
    logic                     wb_regwrite;
    logic [REG_ADDR-1:0]      wb_rd;
    logic [DATA_WIDTH-1:0]    wb_result;

    // stage outputs
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     ex_valid;
    logic                     ex_regwrite;
    logic                     ex_memread;
    logic                     ex_memwrite;
    logic [REG_ADDR-1:0]      ex_rd;
    logic [DATA_WIDTH-1:0]    ex_pc;
    logic [DATA_WIDTH-1:0]    ex_store_data;
    logic                     load_use_stall;

    modport master (
        output id_valid, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_rs1, id_rs2, id_rd, id_asel, id_alusrc, id_operation,
               id_regwrite, id_memread, id_memwrite,
               stall, flush,
               mem_regwrite, mem_rd, mem_result,
               wb_regwrite, wb_rd, wb_result,
        input  SrcA, SrcB, Operation, ex_valid, ex_regwrite, ex_memread,
               ex_memwrite, ex_rd, ex_pc, ex_store_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_pc,
               id_rs1, id_rs2, id_rd, id_asel, id_alusrc, id_operation,
               id_regwrite, id_memread, id_memwrite,
               stall, flush,
               mem_regwrite, mem_rd, mem_result,
               wb_regwrite, wb_rd, wb_result,
        output SrcA, SrcB, Operation, ex_valid, ex_regwrite, ex_memread,
               ex_memwrite, ex_rd, ex_pc, ex_store_data, load_use_stall
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ID/EX pipeline register plus ALU operand selection. Captures decoded
// fields from ID, forwards results from EX/MEM and MEM/WB onto the stored
// register operands, and drives SrcA/SrcB/Operation. Detects a load in EX
// feeding the instruction in ID and inserts one bubble.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the ID/EX register
//   bus   : ex_operand_stage_if.slave (ID fields, stall/flush, forwarding
//           sources in; ALU operands and registered EX control out)
module ex_operand_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    ex_operand_stage_if.slave     bus
);

    // ID/EX register contents. A bubble is the all-zero value, which is
    // also the reset value: invalid, no side-effect controls, rd=x0, op=0.
    typedef struct packed {
        logic                     valid;
        logic                     regwrite;
        logic                     memread;
        logic                     memwrite;
        logic                     asel;
        logic                     alusrc;
        logic [OPCODE_LENGTH-1:0] operation;
        logic [REG_ADDR-1:0]      rs1;
        logic [REG_ADDR-1:0]      rs2;
        logic [REG_ADDR-1:0]      rd;
        logic [DATA_WIDTH-1:0]    rs1_data;
        logic [DATA_WIDTH-1:0]    rs2_data;
        logic [DATA_WIDTH-1:0]    imm;
        logic [DATA_WIDTH-1:0]    pc;
    } idex_t;

    idex_t idex_q;
    idex_t idex_capture;

    logic                  load_use;
    logic                  rs1_hit;
    logic                  rs2_hit;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    always_comb begin
        idex_capture           = '0;
        idex_capture.valid     = bus.id_valid;
        idex_capture.regwrite  = bus.id_regwrite;
        idex_capture.memread   = bus.id_memread;
        idex_capture.memwrite  = bus.id_memwrite;
        idex_capture.asel      = bus.id_asel;
        idex_capture.alusrc    = bus.id_alusrc;
        idex_capture.operation = bus.id_operation;
        idex_capture.rs1       = bus.id_rs1;
        idex_capture.rs2       = bus.id_rs2;
        idex_capture.rd        = bus.id_rd;
        idex_capture.rs1_data  = bus.id_rs1_data;
        idex_capture.rs2_data  = bus.id_rs2_data;
        idex_capture.imm       = bus.id_imm;
        idex_capture.pc        = bus.id_pc;
    end

    // Load-use hazard: only operands the dependent instruction actually
    // reads count. A store reads rs2 as store data even with alusrc=1.
    always_comb begin
        rs1_hit  = !bus.id_asel && (idex_q.rd == bus.id_rs1);
        rs2_hit  = (!bus.id_alusrc || bus.id_memwrite) && (idex_q.rd == bus.id_rs2);
        load_use = idex_q.valid && idex_q.memread && (idex_q.rd != '0)
                   && bus.id_valid && (rs1_hit || rs2_hit);
    end

    // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 is never
    // forwarded since its architectural value is always zero.
    always_comb begin
        fwd_rs1 = idex_q.rs1_data;
        if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == idex_q.rs1)) begin
            fwd_rs1 = bus.mem_result;
        end else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == idex_q.rs1)) begin
            fwd_rs1 = bus.wb_result;
        end
    end

    always_comb begin
        fwd_rs2 = idex_q.rs2_data;
        if (bus.mem_regwrite && (bus.mem_rd != '0) && (bus.mem_rd == idex_q.rs2)) begin
            fwd_rs2 = bus.mem_result;
        end else if (bus.wb_regwrite && (bus.wb_rd != '0) && (bus.wb_rd == idex_q.rs2)) begin
            fwd_rs2 = bus.wb_result;
        end
    end

    // Priority: reset > flush > stall (hold) > load-use bubble > capture.
    // Under stall the hazard is simply re-evaluated next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else if (bus.flush) begin
            idex_q <= '0;
        end else if (!bus.stall) begin
            if (load_use) begin
                idex_q <= '0;
            end else begin
                idex_q <= idex_capture;
            end
        end
    end

    assign bus.SrcA           = idex_q.asel ? idex_q.pc : fwd_rs1;
    assign bus.SrcB           = idex_q.alusrc ? idex_q.imm : fwd_rs2;
    assign bus.ex_store_data  = fwd_rs2;
    assign bus.Operation      = idex_q.operation;
    assign bus.ex_valid       = idex_q.valid;
    assign bus.ex_regwrite    = idex_q.regwrite;
    assign bus.ex_memread     = idex_q.memread;
    assign bus.ex_memwrite    = idex_q.memwrite;
    assign bus.ex_rd          = idex_q.rd;
    assign bus.ex_pc          = idex_q.pc;
    assign bus.load_use_stall = load_use;

endmodule
